// File: rtl/ldlt_pkg.sv
// Shared op codes and phase encodings for the LDLT command scheduler.
package ldlt_pkg;

    localparam int IDX_W_DEF = 10;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LOAD = 3'd1,
        OP_DIV0 = 3'd2,
        OP_ACC  = 3'd3,
        OP_FIN  = 3'd4,
        OP_DUMP = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_LOAD = 2'd1,
        PH_FACT = 2'd2,
        PH_DUMP = 2'd3
    } phase_e;

endpackage

// File: rtl/ldlt_tri_walker.sv
// Lower-triangle index walker (j outer, i = j..DIM-1 inner).
// Exposes the position that will be current after this cycle's clr/adv.
module ldlt_tri_walker #(
    parameter int DIM   = 4,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [IDX_W-1:0] o_nxt_i,
    output logic [IDX_W-1:0] o_nxt_j,
    output logic             o_nxt_last
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DIM - 1);

    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr) begin
            i_d = '0;
            j_d = '0;
        end else if (adv) begin
            if (i_q == MAX_IDX) begin
                // End of the triangle rewinds so the next phase starts at (0,0)
                if (j_q == MAX_IDX) begin
                    i_d = '0;
                    j_d = '0;
                end else begin
                    j_d = j_q + 1'b1;
                    i_d = j_q + 1'b1;
                end
            end else begin
                i_d = i_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign o_nxt_i    = i_d;
    assign o_nxt_j    = j_d;
    assign o_nxt_last = (i_d == MAX_IDX) && (j_d == MAX_IDX);

endmodule

// File: rtl/ldlt_loop_sched.sv
// LOAD / FACT / DUMP command scheduler for the LDLT datapath.
// One (op,i,j,k) command per valid/ready handshake, all outputs registered.
module ldlt_loop_sched
    import ldlt_pkg::*;
#(
    parameter int NODE_NUM = 100,
    parameter int DIM      = 6 * NODE_NUM,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_cmd_ready,
    output logic             o_cmd_valid,
    output logic [2:0]       o_cmd_op,
    output logic [IDX_W-1:0] o_cmd_i,
    output logic [IDX_W-1:0] o_cmd_j,
    output logic [IDX_W-1:0] o_cmd_k,
    output logic             o_cmd_last,
    output logic [1:0]       o_phase,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(DIM - 1);
    localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'((DIM > 1) ? DIM - 2 : 0);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);
    localparam bit               HAS_FACT = (DIM > 1);

    function automatic op_e fact_op(
        input logic [IDX_W-1:0] j,
        input logic [IDX_W-1:0] k
    );
        op_e op;
        op = OP_ACC;
        if (j == '0) begin
            op = OP_DIV0;
        end else if (k == j - ONE) begin
            op = OP_FIN;
        end
        return op;
    endfunction

    function automatic logic fact_last(
        input logic [IDX_W-1:0] i,
        input logic [IDX_W-1:0] j,
        input logic [IDX_W-1:0] k
    );
        return (i == MAX_IDX) && (j == PEN_IDX)
            && (fact_op(j, k) != OP_ACC);
    endfunction

    phase_e           phase_q, phase_d;
    op_e              op_q, op_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] ci_q, ci_d;
    logic [IDX_W-1:0] cj_q, cj_d;
    logic [IDX_W-1:0] ck_q, ck_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] fi_q, fi_d;
    logic [IDX_W-1:0] fj_q, fj_d;
    logic [IDX_W-1:0] fk_q, fk_d;
    logic [IDX_W-1:0] f_ni, f_nj, f_nk;
    logic [IDX_W-1:0] w_i, w_j;
    logic             w_last;
    logic             walk_clr;
    logic             walk_adv;
    logic             accept;

    assign accept = valid_q & i_cmd_ready;

    ldlt_tri_walker #(
        .DIM   (DIM),
        .IDX_W (IDX_W)
    ) u_walker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (walk_clr),
        .adv        (walk_adv),
        .o_nxt_i    (w_i),
        .o_nxt_j    (w_j),
        .o_nxt_last (w_last)
    );

    // Successor of the current FACT position in the i/j/k nest
    always_comb begin
        f_ni = fi_q;
        f_nj = fj_q;
        f_nk = fk_q;
        if (fj_q != '0 && fk_q != fj_q - ONE) begin
            f_nk = fk_q + ONE;
        end else if (fj_q != fi_q - ONE) begin
            f_nj = fj_q + ONE;
            f_nk = '0;
        end else begin
            f_ni = fi_q + ONE;
            f_nj = '0;
            f_nk = '0;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        valid_d  = valid_q;
        op_d     = op_q;
        ci_d     = ci_q;
        cj_d     = cj_q;
        ck_d     = ck_q;
        last_d   = last_q;
        done_d   = 1'b0;
        fi_d     = fi_q;
        fj_d     = fj_q;
        fk_d     = fk_q;
        walk_clr = 1'b0;
        walk_adv = 1'b0;

        if (phase_q == PH_IDLE) begin
            if (i_start) begin
                phase_d = PH_LOAD;
                valid_d = 1'b1;
                op_d    = OP_LOAD;
                ci_d    = w_i;
                cj_d    = w_j;
                ck_d    = '0;
                last_d  = w_last;
            end
        end else if (i_abort) begin
            phase_d  = PH_IDLE;
            valid_d  = 1'b0;
            op_d     = OP_NONE;
            ci_d     = '0;
            cj_d     = '0;
            ck_d     = '0;
            last_d   = 1'b0;
            walk_clr = 1'b1;
            fi_d     = '0;
            fj_d     = '0;
            fk_d     = '0;
        end else if (accept) begin
            walk_adv = (phase_q != PH_FACT);
            if (phase_q == PH_FACT && !last_q) begin
                fi_d   = f_ni;
                fj_d   = f_nj;
                fk_d   = f_nk;
                ci_d   = f_ni;
                cj_d   = f_nj;
                ck_d   = f_nk;
                op_d   = fact_op(f_nj, f_nk);
                last_d = fact_last(f_ni, f_nj, f_nk);
            end else if (phase_q == PH_LOAD && last_q && HAS_FACT) begin
                phase_d = PH_FACT;
                fi_d    = ONE;
                fj_d    = '0;
                fk_d    = '0;
                ci_d    = ONE;
                cj_d    = '0;
                ck_d    = '0;
                op_d    = OP_DIV0;
                last_d  = fact_last(ONE, '0, '0);
            end else if (phase_q == PH_DUMP && last_q) begin
                phase_d = PH_IDLE;
                valid_d = 1'b0;
                op_d    = OP_NONE;
                ci_d    = '0;
                cj_d    = '0;
                ck_d    = '0;
                last_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                // Walker-driven command; a phase end here always lands in DUMP
                if (last_q) begin
                    phase_d = PH_DUMP;
                end
                op_d   = (phase_d == PH_LOAD) ? OP_LOAD : OP_DUMP;
                ci_d   = w_i;
                cj_d   = w_j;
                ck_d   = '0;
                last_d = w_last;
                if (phase_q == PH_FACT) begin
                    fi_d = '0;
                    fj_d = '0;
                    fk_d = '0;
                end
            end
        end

        busy_d = (phase_d != PH_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            valid_q <= 1'b0;
            op_q    <= OP_NONE;
            ci_q    <= '0;
            cj_q    <= '0;
            ck_q    <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fi_q    <= '0;
            fj_q    <= '0;
            fk_q    <= '0;
        end else begin
            phase_q <= phase_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            ci_q    <= ci_d;
            cj_q    <= cj_d;
            ck_q    <= ck_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fi_q    <= fi_d;
            fj_q    <= fj_d;
            fk_q    <= fk_d;
        end
    end

    assign o_cmd_valid = valid_q;
    assign o_cmd_op    = op_q;
    assign o_cmd_i     = ci_q;
    assign o_cmd_j     = cj_q;
    assign o_cmd_k     = ck_q;
    assign o_cmd_last  = last_q;
    assign o_phase     = phase_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_ldlt_loop_sched.sv
// Bench for ldlt_loop_sched: queue model of the loop schedule (DIM=4)
// plus directed DIM=1 sequence and literal schedule tables.
module tb_ldlt_loop_sched;

    localparam int DA = 4;
    localparam int IW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          start_a, abort_a, ready_a;
    logic          valid_a, last_a, busy_a, done_a;
    logic [2:0]    op_a;
    logic [1:0]    phase_a;
    logic [IW-1:0] i_a, j_a, k_a;

    logic          start_b, abort_b, ready_b;
    logic          valid_b, last_b, busy_b, done_b;
    logic [2:0]    op_b;
    logic [1:0]    phase_b;
    logic [IW-1:0] i_b, j_b, k_b;

    ldlt_loop_sched #(.NODE_NUM(1), .DIM(DA), .IDX_W(IW)) u_a (
        .clk(clk), .rst_n(rst_n),
        .i_start(start_a), .i_abort(abort_a), .i_cmd_ready(ready_a),
        .o_cmd_valid(valid_a), .o_cmd_op(op_a),
        .o_cmd_i(i_a), .o_cmd_j(j_a), .o_cmd_k(k_a),
        .o_cmd_last(last_a), .o_phase(phase_a),
        .o_busy(busy_a), .o_done(done_a)
    );

    ldlt_loop_sched #(.NODE_NUM(1), .DIM(1), .IDX_W(IW)) u_b (
        .clk(clk), .rst_n(rst_n),
        .i_start(start_b), .i_abort(abort_b), .i_cmd_ready(ready_b),
        .o_cmd_valid(valid_b), .o_cmd_op(op_b),
        .o_cmd_i(i_b), .o_cmd_j(j_b), .o_cmd_k(k_b),
        .o_cmd_last(last_b), .o_phase(phase_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    typedef struct packed {
        logic [1:0]    ph;
        logic [2:0]    op;
        logic [IW-1:0] i;
        logic [IW-1:0] j;
        logic [IW-1:0] k;
        logic          last;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t acc_log[$];
    cmd_t snap;
    bit   snap_v;
    bit   exp_done;
    int   checks, errors, done_seen, ph2_b;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
        end
    endtask

    function void add(input int ph, input int op, input int i,
                      input int j, input int k);
        cmd_t c;
        c.ph = 2'(ph);
        c.op = 3'(op);
        c.i = IW'(i);
        c.j = IW'(j);
        c.k = IW'(k);
        c.last = 1'b0;
        exp_q.push_back(c);
    endfunction

    function void mark_last();
        exp_q[exp_q.size() - 1].last = 1'b1;
    endfunction

    // Full LOAD/FACT/DUMP schedule straight from the loop definitions
    function void build_run();
        int n0;
        for (int j = 0; j < DA; j++)
            for (int i = j; i < DA; i++) add(1, 1, i, j, 0);
        mark_last();
        n0 = exp_q.size();
        for (int i = 1; i < DA; i++)
            for (int j = 0; j < i; j++) begin
                if (j == 0) add(2, 2, i, 0, 0);
                else
                    for (int k = 0; k < j; k++)
                        add(2, (k == j - 1) ? 4 : 3, i, j, k);
            end
        if (exp_q.size() > n0) mark_last();
        for (int j = 0; j < DA; j++)
            for (int i = j; i < DA; i++) add(3, 5, i, j, 0);
        mark_last();
    endfunction

    always @(negedge clk) begin
        logic [38:0] got, want;
        if (rst_n) begin
            got = {valid_a, busy_a, done_a, phase_a, op_a,
                   i_a, j_a, k_a, last_a};
            if (exp_q.size() != 0) want = {1'b1, 1'b1, exp_done, exp_q[0]};
            else want = {1'b0, 1'b0, exp_done, 36'd0};
            chk("cycle", 64'(got), 64'(want));
            if (done_a) done_seen++;
            snap = {phase_a, op_a, i_a, j_a, k_a, last_a};
            snap_v = valid_a;
            if (phase_b == 2'd2) ph2_b++;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_done = 1'b0;
            snap_v = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (snap_v && ready_a && !abort_a) acc_log.push_back(snap);
            if (exp_q.size() != 0) begin
                if (abort_a) exp_q.delete();
                else if (ready_a) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) exp_done = 1'b1;
                end
            end else if (start_a) begin
                build_run();
            end
        end
    end

    task automatic pulse_a();
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic run_until(input int target, input int budget,
                             input bit rnd);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (done_seen >= target) break;
            if (rnd) ready_a = 1'($urandom_range(0, 1));
        end
        ready_a = 1'b1;
        chk("done_cnt", 64'(done_seen), 64'(target));
    endtask

    int li[10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
    int lj[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    int fi[7]  = '{1, 2, 2, 3, 3, 3, 3};
    int fj[7]  = '{0, 0, 1, 0, 1, 2, 2};
    int fk[7]  = '{0, 0, 0, 0, 0, 0, 1};
    int fo[7]  = '{2, 2, 4, 2, 4, 3, 4};

    initial begin
        int diffs;
        bit found;
        rst_n = 1'b0;
        start_a = 0; abort_a = 0; ready_a = 1;
        start_b = 0; abort_b = 0; ready_b = 1;
        checks = 0; errors = 0; done_seen = 0; ph2_b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", 64'({valid_a, busy_a, done_a, phase_a, op_a,
                          i_a, j_a, k_a, last_a}), 64'd0);
        chk("rst_b", 64'({valid_b, busy_b, done_b, phase_b, op_b,
                          i_b, j_b, k_b, last_b}), 64'd0);
        rst_n = 1'b1;

        acc_log.delete();
        pulse_a();
        run_until(1, 200, 1'b0);
        chk("run1_len", 64'(acc_log.size()), 64'd27);
        if (acc_log.size() == 27) begin
            for (int n = 0; n < 10; n++) begin
                chk("load_cmd", 64'({acc_log[n].ph, acc_log[n].op,
                    acc_log[n].i, acc_log[n].j, acc_log[n].k}),
                    64'({2'd1, 3'd1, 10'(li[n]), 10'(lj[n]), 10'd0}));
                chk("dump_cmd", 64'({acc_log[17+n].ph, acc_log[17+n].op,
                    acc_log[17+n].i, acc_log[17+n].j, acc_log[17+n].k}),
                    64'({2'd3, 3'd5, 10'(li[n]), 10'(lj[n]), 10'd0}));
            end
            for (int n = 0; n < 7; n++)
                chk("fact_cmd", 64'({acc_log[10+n].ph, acc_log[10+n].op,
                    acc_log[10+n].i, acc_log[10+n].j, acc_log[10+n].k}),
                    64'({2'd2, 3'(fo[n]), 10'(fi[n]), 10'(fj[n]),
                         10'(fk[n])}));
            chk("last_flags", 64'({acc_log[8].last, acc_log[9].last,
                acc_log[15].last, acc_log[16].last,
                acc_log[25].last, acc_log[26].last}), 64'b010101);
        end

        pulse_a();
        run_until(2, 2000, 1'b1);
        chk("bp_len", 64'(acc_log.size()), 64'd54);
        if (acc_log.size() == 54) begin
            diffs = 0;
            for (int n = 0; n < 27; n++)
                if (acc_log[27+n] != acc_log[n]) diffs++;
            chk("bp_stream", 64'(diffs), 64'd0);
        end

        pulse_a();
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (phase_a == 2'd2 && i_a == 10'd2 && j_a == 10'd1) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reach", 64'(found), 64'd1);
        abort_a = 1'b1;
        @(posedge clk);
        #1;
        abort_a = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_idle", 64'({phase_a, valid_a, busy_a, done_a}), 64'd0);
        pulse_a();
        @(negedge clk);
        #1;
        chk("restart", 64'({valid_a, phase_a, op_a, i_a, j_a}),
            64'({1'b1, 2'd1, 3'd1, 10'd0, 10'd0}));
        run_until(3, 200, 1'b0);

        start_a = 1'b1;
        run_until(5, 400, 1'b0);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("held_idle", 64'({busy_a, valid_a}), 64'd0);

        pulse_a();
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({valid_a, busy_a, done_a, phase_a, op_a,
                              i_a, j_a, k_a, last_a}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst", 64'({done_a, valid_a, busy_a}), 64'd0);
        chk("no_rst_done", 64'(done_seen), 64'd5);

        @(posedge clk);
        #1;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        @(negedge clk);
        #1;
        chk("b_load", 64'({valid_b, phase_b, op_b, i_b, j_b, k_b,
                           last_b, done_b}),
            64'({1'b1, 2'd1, 3'd1, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0}));
        @(negedge clk);
        #1;
        chk("b_dump", 64'({valid_b, phase_b, op_b, i_b, j_b, k_b,
                           last_b, done_b}),
            64'({1'b1, 2'd3, 3'd5, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0}));
        @(negedge clk);
        #1;
        chk("b_done", 64'({valid_b, phase_b, busy_b, done_b}),
            64'({1'b0, 2'd0, 1'b0, 1'b1}));
        @(negedge clk);
        #1;
        chk("b_done_once", 64'({done_b, busy_b}), 64'd0);
        chk("b_no_fact", 64'(ph2_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
